sbox_cfg_ctrl: RTL and testbench

SBOX_CFG_CTRL -- requirements
Module: sbox_cfg_ctrl

---
 rtl/sbox_cfg_ctrl.sv | 157 +++++++++++++++
 tb/tb_sbox_cfg_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_cfg_ctrl.sv
// S-box configuration controller: turns single-entry write commands and
// 64-nibble table-load streams into registered write strobes for the S-box bank.
module sbox_cfg_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_mode,
    input  logic [2:0] cmd_sbox,
    input  logic [1:0] cmd_row,
    input  logic [3:0] cmd_col,
    input  logic [3:0] cmd_val,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_data,
    input  logic       des_busy,
    input  logic       abort,
    output logic       edit_sbox,
    output logic [2:0] sbox_sel,
    output logic [1:0] row_sel,
    output logic [3:0] col_sel,
    output logic [3:0] new_sbox_val,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_LOAD   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [2:0] cap_sbox_q, cap_sbox_d;
    logic [1:0] cap_row_q, cap_row_d;
    logic [3:0] cap_col_q, cap_col_d;
    logic [3:0] cap_val_q, cap_val_d;
    logic       edit_q, edit_d;
    logic [2:0] sbox_sel_q, sbox_sel_d;
    logic [1:0] row_sel_q, row_sel_d;
    logic [3:0] col_sel_q, col_sel_d;
    logic [3:0] val_q, val_d;
    logic       done_q, done_d;
    logic       cmd_fire;
    logic       load_fire;

    assign cmd_ready  = (state_q == S_IDLE) && !abort && !rst;
    assign load_ready = (state_q == S_LOAD) && !des_busy && !abort && !rst;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign load_fire  = load_valid && load_ready;
    assign busy       = (state_q != S_IDLE);

    assign edit_sbox    = edit_q;
    assign sbox_sel     = sbox_sel_q;
    assign row_sel      = row_sel_q;
    assign col_sel      = col_sel_q;
    assign new_sbox_val = val_q;
    assign done         = done_q;

    // Strobe and done default low; select/data hold their last written value.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cap_sbox_d = cap_sbox_q;
        cap_row_d  = cap_row_q;
        cap_col_d  = cap_col_q;
        cap_val_d  = cap_val_q;
        edit_d     = 1'b0;
        sbox_sel_d = sbox_sel_q;
        row_sel_d  = row_sel_q;
        col_sel_d  = col_sel_q;
        val_d      = val_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        cap_sbox_d = cmd_sbox;
                        cap_row_d  = cmd_row;
                        cap_col_d  = cmd_col;
                        cap_val_d  = cmd_val;
                        idx_d      = 6'd0;
                        state_d    = cmd_mode ? S_LOAD : S_SINGLE;
                    end
                end
                S_SINGLE: begin
                    if (!des_busy) begin
                        edit_d     = 1'b1;
                        sbox_sel_d = cap_sbox_q;
                        row_sel_d  = cap_row_q;
                        col_sel_d  = cap_col_q;
                        val_d      = cap_val_q;
                        state_d    = S_FINISH;
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        edit_d     = 1'b1;
                        sbox_sel_d = cap_sbox_q;
                        row_sel_d  = idx_q[5:4];
                        col_sel_d  = idx_q[3:0];
                        val_d      = load_data;
                        idx_d      = idx_q + 6'd1;
                        if (idx_q == 6'd63) begin
                            state_d = S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // Final write is on the outputs this cycle; done follows it.
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd0;
            cap_sbox_q <= 3'd0;
            cap_row_q  <= 2'd0;
            cap_col_q  <= 4'd0;
            cap_val_q  <= 4'd0;
            edit_q     <= 1'b0;
            sbox_sel_q <= 3'd0;
            row_sel_q  <= 2'd0;
            col_sel_q  <= 4'd0;
            val_q      <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cap_sbox_q <= cap_sbox_d;
            cap_row_q  <= cap_row_d;
            cap_col_q  <= cap_col_d;
            cap_val_q  <= cap_val_d;
            edit_q     <= edit_d;
            sbox_sel_q <= sbox_sel_d;
            row_sel_q  <= row_sel_d;
            col_sel_q  <= col_sel_d;
            val_q      <= val_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// Scoreboard bench for sbox_cfg_ctrl: a transaction-level model predicts each
// write and done pulse with its cycle; a negedge monitor pops and compares.
module tb_sbox_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_mode;
    logic [2:0] cmd_sbox;
    logic [1:0] cmd_row;
    logic [3:0] cmd_col, cmd_val;
    logic       load_valid, load_ready;
    logic [3:0] load_data;
    logic       des_busy, abort;
    logic       edit_sbox;
    logic [2:0] sbox_sel;
    logic [1:0] row_sel;
    logic [3:0] col_sel, new_sbox_val;
    logic       busy, done;

    sbox_cfg_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_sbox(cmd_sbox), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_val(cmd_val),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .des_busy(des_busy), .abort(abort),
        .edit_sbox(edit_sbox), .sbox_sel(sbox_sel), .row_sel(row_sel),
        .col_sel(col_sel), .new_sbox_val(new_sbox_val),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] sb;
        logic [1:0] r;
        logic [3:0] c;
        logic [3:0] v;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    // Reference model: a pending operation (none / single / load / wrap-up),
    // the next nibble number of a load, the captured command, and the
    // select/data value the outputs should currently be holding.
    int         m_ph;
    int         m_idx;
    bit         m_acc;
    logic [2:0] c_sb;
    logic [1:0] c_r;
    logic [3:0] c_c, c_v;
    logic [12:0] m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_chk++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_write(input int e, input logic [2:0] sb, input logic [1:0] r,
                                input logic [3:0] c, input logic [3:0] v);
        wr_t w;
        w.cyc = e; w.sb = sb; w.r = r; w.c = c; w.v = v;
        wq.push_back(w);
        m_out = {sb, r, c, v};
    endtask

    task automatic predict();
        int e;
        e = cyc + 1;
        m_acc = 1'b0;
        if (rst) begin
            m_ph = 0; m_idx = 0; m_out = '0;
        end else if (abort) begin
            m_ph = 0; m_idx = 0;
        end else begin
            case (m_ph)
                0: if (cmd_valid) begin
                    m_acc = 1'b1;
                    c_sb = cmd_sbox; c_r = cmd_row; c_c = cmd_col; c_v = cmd_val;
                    m_idx = 0;
                    m_ph = cmd_mode ? 2 : 1;
                end
                1: if (!des_busy) begin
                    expect_write(e, c_sb, c_r, c_c, c_v);
                    m_ph = 3;
                end
                2: if (load_valid && !des_busy) begin
                    expect_write(e, c_sb, 2'(m_idx / 16), 4'(m_idx % 16), load_data);
                    m_idx++;
                    if (m_idx == 64) begin
                        m_idx = 0;
                        m_ph = 3;
                    end
                end
                default: begin
                    dq.push_back(e);
                    m_ph = 0;
                end
            endcase
        end
    endtask

    // Called just after an edge with new inputs applied: check the
    // handshake/held outputs, predict the next edge, then advance one cycle.
    task automatic tick();
        bit pre_rst;
        #1;
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ph == 0 && !abort && !rst));
            chk("load_ready", 32'(load_ready), 32'(m_ph == 2 && !des_busy && !abort && !rst));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            chk("sel_hold", 32'({sbox_sel, row_sel, col_sel, new_sbox_val}), 32'(m_out));
        end
        pre_rst = rst;
        predict();
        @(posedge clk);
        #1;
        if (pre_rst) chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        wr_t w;
        int  d;
        if (chk_en) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                fail_now("write_missing", cyc, w.cyc);
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
                d = dq.pop_front();
                fail_now("done_missing", cyc, d);
            end
            if (edit_sbox !== 1'b0) begin
                if (edit_sbox !== 1'b1 || wq.size() == 0) begin
                    fail_now("write_unexpected", 1, 0);
                end else begin
                    w = wq.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(w.cyc));
                    chk("write_fields", 32'({sbox_sel, row_sel, col_sel, new_sbox_val}),
                        32'({w.sb, w.r, w.c, w.v}));
                end
            end
            if (done !== 1'b0) begin
                if (done !== 1'b1 || dq.size() == 0) begin
                    fail_now("done_unexpected", 1, 0);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d));
                end
            end
        end
    end

    task automatic send_cmd(input logic mode, input logic [2:0] sb, input logic [1:0] r,
                            input logic [3:0] c, input logic [3:0] v);
        bit ok;
        ok = 1'b0;
        cmd_mode = mode; cmd_sbox = sb; cmd_row = r; cmd_col = c; cmd_val = v;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_acc) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) fail_now("cmd_accept_timeout", 0, 1);
    endtask

    task automatic feed_until(input int stop);
        bit ok;
        ok = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (m_ph != 2 || m_idx == stop) begin
                ok = 1'b1;
                break;
            end
            load_data = 4'(m_idx);
            tick();
        end
        if (!ok) fail_now("feed_timeout", m_idx, stop);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_ph == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("idle_timeout", m_ph, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_ph = 0; m_idx = 0; m_acc = 1'b0; m_out = '0;
        c_sb = '0; c_r = '0; c_c = '0; c_v = '0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_sbox = '0; cmd_row = '0;
        cmd_col = '0; cmd_val = '0; load_valid = 1'b0; load_data = '0;
        des_busy = 1'b0; abort = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single write 5/2/9/A
        send_cmd(1'b0, 3'd5, 2'd2, 4'd9, 4'hA);
        wait_idle();
        tick();

        // Full back-to-back load of S-box 3
        send_cmd(1'b1, 3'd3, 2'd0, 4'd0, 4'd0);
        feed_until(-1);
        load_valid = 1'b0;
        wait_idle();
        tick();

        // des_busy stall after nibble 20
        send_cmd(1'b1, 3'd6, 2'd1, 4'd1, 4'd1);
        feed_until(21);
        des_busy = 1'b1;
        repeat (10) tick();
        des_busy = 1'b0;
        feed_until(-1);
        load_valid = 1'b0;
        wait_idle();

        // Abort at nibble 40, then a single write
        send_cmd(1'b1, 3'd1, 2'd0, 4'd0, 4'd0);
        feed_until(40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        load_valid = 1'b0;
        tick();
        send_cmd(1'b0, 3'd7, 2'd3, 4'd15, 4'h5);
        wait_idle();

        // Reset mid-load, then a fresh load from index 0
        send_cmd(1'b1, 3'd2, 2'd0, 4'd0, 4'd0);
        feed_until(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_valid = 1'b0;
        tick();
        send_cmd(1'b1, 3'd4, 2'd0, 4'd0, 4'd0);
        feed_until(-1);
        load_valid = 1'b0;
        wait_idle();

        // Commands presented during a load are ignored
        send_cmd(1'b1, 3'd0, 2'd0, 4'd0, 4'd0);
        load_valid = 1'b1;
        for (int i = 0; i < 300 && m_ph == 2; i++) begin
            cmd_valid = (m_idx >= 5 && m_idx < 10);
            cmd_mode = 1'($urandom); cmd_sbox = 3'($urandom);
            cmd_row = 2'($urandom); cmd_col = 4'($urandom); cmd_val = 4'($urandom);
            load_data = 4'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        load_valid = 1'b0;
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom % 4) == 0;
            cmd_mode   = 1'($urandom);
            cmd_sbox   = 3'($urandom);
            cmd_row    = 2'($urandom);
            cmd_col    = 4'($urandom);
            cmd_val    = 4'($urandom);
            load_valid = ($urandom % 5) != 0;
            load_data  = 4'($urandom);
            des_busy   = ($urandom % 8) == 0;
            abort      = ($urandom % 80) == 0;
            rst        = ($urandom % 300) == 0;
            tick();
        end
        cmd_valid = 1'b0; load_valid = 1'b0; des_busy = 1'b0; rst = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();

        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("dones_drained", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
